instr_mem_sync: RTL
===================

Name: instr_mem_sync

Overview:
- Parametrised, clocked instruction memory for the ARM pipeline IF stage; replaces the fixed combinational PC-to-instruction lookup.
- Word-addressed RAM with:
  - registered read, with request/valid and freeze (stall) handling;
  - a program-load write port;
  - a post-reset clear sequencer;
  - fault flagging for misaligned or out-of-range PCs.

Parameters:
- WORD_WIDTH, 32, instruction width in bits.
- DEPTH, 64, number of instruction words (power of two, >= 2).
- NOP_WORD, 32'h00000000, value driven on instruction for faulted fetches and during reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- rd_en  input  1  fetch request for pc this cycle.
- pc  input  32  byte address of the fetch.
- freeze  input  1  IF stall; holds outputs and blocks acceptance of rd_en.
- instruction  output  WORD_WIDTH  fetched word (registered).
- instr_valid  output  1  instruction/fault hold a fetch result accepted the previous cycle.
- fault  output  1  accompanying fetch was misaligned or out of range.
- ld_en  input  1  program-load write strobe.
- ld_addr  input  32  byte address of load word.
- ld_data  input  WORD_WIDTH  load data.
- ld_err  output  1  one-cycle pulse: previous load was dropped (misaligned or out of range).
- busy  output  1  clear sequence in progress; fetches and loads are ignored.

Behaviour:
- AW = clog2(DEPTH). Word index = addr[AW+1:2].
  - Aligned: addr[1:0] == 0.
  - In range: addr < DEPTH*4, compared over the full 32 bits.
- Async reset (rst=1), immediate, including mid-fetch and mid-load:
  - instruction = NOP_WORD; instr_valid = 0; fault = 0; ld_err = 0; busy = 1;
  - state = CLEAR; clear counter = 0.
- FSM, state CLEAR:
  - Each cycle writes NOP_WORD to mem[counter], then counter += 1.
  - After the write of index DEPTH-1, go to READY. busy falls on the first READY cycle.
  - Total duration: exactly DEPTH cycles after rst deassertion.
  - rd_en and ld_en are ignored. instr_valid stays 0; ld_err stays 0.
- FSM, state READY: remains there until rst.
- Fetch (READY only):
  - Accepted when rd_en=1 and freeze=0 at edge N. Result is visible after edge N+1, i.e. 1-cycle latency.
  - Aligned and in range: instruction = mem[index], fault = 0, instr_valid = 1.
  - Otherwise: instruction = NOP_WORD, fault = 1, instr_valid = 1. Memory is not read.
  - freeze=1: instruction, instr_valid and fault hold their values; rd_en is not accepted.
  - rd_en=0 and freeze=0: instr_valid = 0 and fault = 0 next cycle; instruction holds.
- Load (READY only, independent of freeze):
  - ld_en=1 with ld_addr aligned and in range writes mem[index] at that edge.
  - Otherwise the write is dropped and ld_err = 1 for the next cycle only.
- Simultaneous fetch and load to the same index: the fetch returns the old word (read-before-write). The new word is visible to fetches accepted at later edges.
- Fetch and load may both be accepted in the same cycle; neither stalls the other.
- PC wrap-around: there is no wrap. pc >= DEPTH*4 always faults; high bits are never truncated into the index.
- rd_en, pc, ld_* are sampled only on clk; there are no combinational paths to outputs.

Test Plan:
- Reset/clear, DEPTH=64:
  - pulse rst, release at cycle 0 -> busy=1 for cycles 0..63 and 0 at cycle 64;
  - then fetch pc=0,4,...,252 -> every word = 0, fault = 0.
- Load then fetch:
  - load 32'hE0811002 @0x00 and 32'hE2833005 @0x04;
  - fetch pc=0x00, then 0x04 on consecutive cycles -> the two words appear one cycle later each, instr_valid = 1.
- Faults:
  - fetch pc=0x02 -> instruction = NOP_WORD, fault = 1, instr_valid = 1;
  - fetch pc=0x100 -> same;
  - load to ld_addr=0x101 -> ld_err = 1 for one cycle and memory unchanged (fetch 0x100 still faults; fetch 0x00 is unchanged).
- Freeze:
  - fetch 0x04, then assert freeze for 3 cycles while changing pc to 0x08 -> instruction stays the 0x04 word with instr_valid = 1;
  - release freeze -> the 0x08 word appears one cycle later.
- Read/write collision:
  - same cycle fetch pc=0x10 and load 32'hDEADBEEF @0x10, old word 32'h12345678 -> output 32'h12345678;
  - next fetch of 0x10 -> 32'hDEADBEEF.
- Reset mid-operation:
  - assert rst during an active fetch stream -> outputs return to reset values immediately;
  - the full DEPTH-cycle clear reruns and previously loaded words read back as 0.

Source files
------------

// File: rtl/instr_mem_sync_if.sv
// ---------------------------------------------------------------------------
// instr_mem_sync_if
// Bundles the fetch, program-load and status signals of the synchronous
// instruction memory.
//   master : IF stage / loader side (drives requests, receives results)
//   slave  : the memory itself
// Signals
//   rd_en, pc, freeze          fetch request, byte address, IF stall
//   instruction, instr_valid,  registered fetch result and its qualifiers
//   fault
//   ld_en, ld_addr, ld_data    program-load write port
//   ld_err                     one-cycle pulse for a dropped load
//   busy                       post-reset clear sequence in progress
// ---------------------------------------------------------------------------
interface instr_mem_sync_if #(
    parameter int WORD_WIDTH = 32
) ();
    logic                  rd_en;
    logic [31:0]           pc;
    logic                  freeze;
    logic [WORD_WIDTH-1:0] instruction;
    logic                  instr_valid;
    logic                  fault;
    logic                  ld_en;
    logic [31:0]           ld_addr;
    logic [WORD_WIDTH-1:0] ld_data;
    logic                  ld_err;
    logic                  busy;

    modport master (
        output rd_en,
        output pc,
        output freeze,
        input  instruction,
        input  instr_valid,
        input  fault,
        output ld_en,
        output ld_addr,
        output ld_data,
        input  ld_err,
        input  busy
    );

    modport slave (
        input  rd_en,
        input  pc,
        input  freeze,
        output instruction,
        output instr_valid,
        output fault,
        input  ld_en,
        input  ld_addr,
        input  ld_data,
        output ld_err,
        output busy
    );
endinterface

// File: rtl/instr_mem_sync.sv
// ---------------------------------------------------------------------------
// instr_mem_sync
// Clocked, word-addressed instruction memory for the IF stage. Fetches have
// one cycle of latency and honour an IF stall (freeze). A program-load port
// writes words while the pipeline runs. After every reset the whole array is
// overwritten with NOP_WORD, one word per cycle, before any fetch or load is
// accepted. Misaligned or out-of-range fetches return NOP_WORD with fault set;
// such loads are dropped and reported on ld_err.
//
// Ports
//   clk   system clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   instr_mem_sync_if.slave (fetch, load and status signals)
//
// States
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_CLEAR | writing NOP_WORD to mem[clr_cnt]; fetches/loads ignored
//   ST_READY | normal operation; left only through rst
// ---------------------------------------------------------------------------
module instr_mem_sync #(
    parameter int                    WORD_WIDTH = 32,
    parameter int                    DEPTH      = 64,
    parameter logic [WORD_WIDTH-1:0] NOP_WORD   = {WORD_WIDTH{1'b0}}
) (
    input logic              clk,
    input logic              rst,
    instr_mem_sync_if.slave  bus
);

    localparam int              AW         = $clog2(DEPTH);
    // Byte-address limit; the full 32-bit address is compared against it so
    // that high bits can never alias back into the array.
    localparam logic [31:0]     ADDR_LIMIT = 32'(DEPTH) * 32'd4;
    localparam logic [AW-1:0]   LAST_IDX   = AW'(DEPTH - 1);

    localparam logic [0:0]      ST_CLEAR   = 1'b0;
    localparam logic [0:0]      ST_READY   = 1'b1;

    logic [WORD_WIDTH-1:0] mem [DEPTH];

    logic [0:0]            state;
    logic [AW-1:0]         clr_cnt;

    logic [WORD_WIDTH-1:0] instr_q;
    logic                  valid_q;
    logic                  fault_q;
    logic                  ld_err_q;

    logic                  is_ready;
    logic                  fetch_ok;
    logic                  ld_ok;
    logic [AW-1:0]         fetch_idx;
    logic [AW-1:0]         ld_idx;
    logic                  ld_take;

    // ---------------------------------------------------------------------
    // Address qualification
    // ---------------------------------------------------------------------
    always_comb begin
        is_ready  = (state == ST_READY);
        fetch_ok  = (bus.pc[1:0] == 2'b00) && (bus.pc < ADDR_LIMIT);
        ld_ok     = (bus.ld_addr[1:0] == 2'b00) && (bus.ld_addr < ADDR_LIMIT);
        fetch_idx = bus.pc[AW+1:2];
        ld_idx    = bus.ld_addr[AW+1:2];
        ld_take   = is_ready && bus.ld_en;
    end

    // ---------------------------------------------------------------------
    // Clear sequencer
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (clr_cnt == LAST_IDX) begin
                        state <= ST_READY;
                    end
                    clr_cnt <= clr_cnt + 1'b1;
                end
                default: begin
                    state <= ST_READY;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Memory array write port. Not reset: the clear sequencer owns
    // initialisation. While rst is held the sequencer sits at index 0 and
    // keeps rewriting mem[0] with NOP_WORD, which the clear pass repeats.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_cnt] <= NOP_WORD;
        end else if (ld_take && ld_ok) begin
            mem[ld_idx] <= bus.ld_data;
        end
    end

    // ---------------------------------------------------------------------
    // Fetch result registers. The read of mem and the load write share an
    // edge, so a same-index collision returns the word from before the load.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else if (!is_ready) begin
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else if (!bus.freeze) begin
            if (bus.rd_en) begin
                valid_q <= 1'b1;
                if (fetch_ok) begin
                    instr_q <= mem[fetch_idx];
                    fault_q <= 1'b0;
                end else begin
                    instr_q <= NOP_WORD;
                    fault_q <= 1'b1;
                end
            end else begin
                valid_q <= 1'b0;
                fault_q <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Dropped-load flag, high for exactly the cycle after the bad request.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_err_q <= 1'b0;
        end else begin
            ld_err_q <= ld_take && !ld_ok;
        end
    end

    assign bus.instruction = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.fault       = fault_q;
    assign bus.ld_err      = ld_err_q;
    assign bus.busy        = (state == ST_CLEAR);

endmodule
